// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RISC-V immediate decoder feeding a two-entry skid-buffered valid/ready output
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);
  localparam int EW = 36 + XLEN;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_head, r_skid, w_ent;
  logic [XLEN-1:0] w_imm;
  logic [2:0] w_type, w_f3;
  logic [6:0] w_op;
  logic w_ill, w_acc, w_pop, w_load_head, w_load_skid, w_shamt;
  logic [CNT_W-1:0] r_cnt;
  assign w_op    = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_shamt = w_f3[1:0] == 2'b01;
  always_comb begin
    w_imm  = '0;
    w_type = 3'd0;
    w_ill  = 1'b0;
    case (w_op)
      7'b0000011, 7'b1100111: begin
        w_imm  = XLEN'($signed(in_instr[31:20]));
        w_type = 3'd1;
      end
      7'b0010011: begin
        w_imm  = w_shamt ? (XLEN == 64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]))
                         : XLEN'($signed(in_instr[31:20]));
        w_type = w_shamt ? 3'd6 : 3'd1;
      end
      7'b0100011: begin
        w_imm  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
        w_type = 3'd2;
      end
      7'b1100011: begin
        w_imm  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
        w_type = 3'd3;
      end
      7'b0110111, 7'b0010111: begin
        w_imm  = XLEN'($signed({in_instr[31:12], 12'b0}));
        w_type = 3'd4;
      end
      7'b1101111: begin
        w_imm  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
        w_type = 3'd5;
      end
      7'b1110011: begin
        w_imm  = w_f3[2] ? XLEN'(in_instr[19:15]) : '0;
        w_type = w_f3[2] ? 3'd7 : 3'd0;
      end
      7'b0110011, 7'b0001111: w_ill = 1'b0;
      default: w_ill = 1'b1;
    endcase
  end
  assign w_ent       = {in_instr, w_imm, w_type, w_ill};
  assign in_ready    = rst_n & (r_state != FULL);
  assign out_valid   = r_state != EMPTY;
  assign w_acc       = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_load_skid = w_acc & (r_state == ONE) & ~w_pop;
  assign w_load_head = (w_acc & ((r_state == EMPTY) | w_pop)) | ((r_state == FULL) & w_pop);
  assign {out_instr, out_imm, out_type, out_illegal} = r_head;
  assign illegal_cnt = r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = w_acc ? ONE : EMPTY;
      ONE:     w_next = (w_acc & ~w_pop) ? FULL : ((~w_acc & w_pop) ? EMPTY : ONE);
      FULL:    w_next = w_pop ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_head) r_head <= (r_state == FULL) ? r_skid : w_ent;
      if (w_load_skid) r_skid <= w_ent;
      if (cnt_clr) r_cnt <= '0;
      else if (w_acc & w_ill & ~&r_cnt) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Pipelined, parametrised immediate decoder for the RISC-V core's decode path. It accepts 32-bit instructions on a valid/ready stream and derives the immediate format from the opcode and funct3 itself; no external select is used. It sign- or zero-extends the immediate to XLEN and presents it, with the instruction and a format tag, on a buffered valid/ready output. It also flags unsupported opcodes and keeps a saturating illegal-instruction count.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- CNT_W, 16, width of the illegal-instruction counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage can accept; equals rst_n AND (state != FULL).
- in_instr  in  32  instruction word.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  instruction passthrough.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  format tag: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- out_illegal  out  1  opcode not supported.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.
- cnt_clr  in  1  synchronous clear of illegal_cnt.

## Operation
- Decode on opcode = instr[6:0]:
  - 0000011 LOAD and 1100111 JALR: I-format, sign-extend instr[31:20].
  - 0010011 OP-IMM with funct3 = 001 or 101: SHAMT format.
    - XLEN=32: zero-extend instr[24:20].
    - XLEN=64: zero-extend instr[25:20].
    - funct7/funct6 bits are dropped.
  - 0010011 OP-IMM, other funct3: I-format.
  - 0100011 STORE: S-format, sign-extend {instr[31:25], instr[11:7]}.
  - 1100011 BRANCH: B-format, sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111 LUI and 0010111 AUIPC: U-format, {instr[31:12], 12'b0}; for XLEN=64, sign-extend from bit 31.
  - 1101111 JAL: J-format, sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 1110011 SYSTEM:
    - funct3[2] = 1: ZIMM format, zero-extend instr[19:15].
    - otherwise: NONE, imm 0.
  - 0110011 OP, 0001111 FENCE: NONE, imm 0, legal.
  - any other opcode: out_illegal = 1, type NONE, imm 0.
- Decode happens on the input side. Registered entries hold {instr, imm, type, illegal}.
- Buffer: two-entry skid buffer. State machine:
  - EMPTY: no entries.
  - ONE: head valid.
  - FULL: head and skid valid.
- Transitions (acc = in_valid & in_ready; pop = out_valid & out_ready):
  - EMPTY: acc -> ONE.
  - ONE: acc & !pop -> FULL. acc & pop -> ONE, with head replaced. !acc & pop -> EMPTY.
  - FULL: pop -> ONE, with skid moving to head. No accept is possible because in_ready = 0.
- Output always presents the head. Order is strictly FIFO, with no loss and no duplication.
- Output fields are stable while out_valid = 1 and out_ready = 0.
- illegal_cnt increments on acceptance of an illegal instruction and saturates at all-ones. If cnt_clr coincides with such an acceptance, clear wins and the result is 0.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = EMPTY, out_valid = 0, illegal_cnt = 0.
  - out_instr, out_imm, out_type and out_illegal all read 0.
  - in_ready is 0 while rst_n = 0.
- Reset mid-stream discards all buffered entries. The first acceptance can occur on the first edge with rst_n = 1.
- Latency: an instruction accepted at edge N appears with out_valid = 1 after edge N.
- Throughput: one instruction per cycle while out_ready = 1.
- in_ready is a function of registered state and rst_n only; there is no combinational path from out_ready.
- No other combinational in-to-out paths exist.

## Test plan
- Basic decode, XLEN=32, out_ready = 1:
  - 0xFFF00093 (addi) -> imm 0xFFFFFFFF, type 1.
  - 0xFE21AE23 (sw -4) -> imm 0xFFFFFFFC, type 2.
  - 0xFE000CE3 (beq -8) -> imm 0xFFFFFFF8, type 3.
  - 0x001000EF (jal +2048) -> imm 0x00000800, type 5.
  - Each appears one cycle after acceptance, back-to-back.
- U, shift and CSR forms:
  - 0x123452B7 -> imm 0x12345000, type 4.
  - 0x01F09093 (slli 31) -> imm 0x1F, type 6.
  - 0x4030D093 (srai 3) -> imm 0x3, type 6.
  - 0x0002D073 (csrrwi, zimm 5) -> imm 0x5, type 7.
- XLEN=64:
  - 0x800002B7 -> imm 0xFFFFFFFF80000000.
  - 0x03F09093 (slli 63) -> imm 0x3F.
  - 0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF.
- Backpressure:
  - Hold out_ready = 0 and drive 3 valid instructions A, B, C. A and B are accepted, then in_ready = 0 and C is held. Head A stays stable.
  - Raise out_ready. Output is A, B, C in order with no duplicates.
  - Simultaneous accept and pop in state ONE keeps state ONE.
- Illegal and counter:
  - Feed 0x00000000 three times -> out_illegal = 1, imm 0, illegal_cnt = 3.
  - Pulse cnt_clr together with a fourth illegal acceptance -> illegal_cnt = 0.
  - With CNT_W = 2, feed 5 illegal instructions -> illegal_cnt saturates at 3.
- Reset mid-operation:
  - Reach state FULL, then assert rst_n = 0 for one edge.
  - Required: out_valid = 0, in_ready = 0 while asserted, illegal_cnt = 0, and no stale entry appears after release.
